cfg_scan_loader: RTL and testbench
==================================

Name: cfg_scan_loader

Overview:
- Parametrised configuration loader for the FPGA fabric.
- Accepts configuration words over a valid/ready stream and shifts them serially, MSB first, into the fabric's LUT/switch-box scan chain.
- Pulses a single update strobe when all words have been shifted, then enables the fabric for user mode.
- Replaces fixed-count, word-at-a-time configuration with a word count and width set at elaboration, plus a handshake-driven sequencer.

Parameters:
- WORD_W, 32, bits per configuration word (LUT memory word / switch-box configure word); must be >= 2.
- NUM_WORDS, 42, configuration words per full load; must be >= 1.
- CNT_W, 6, width of word/bit counters; must satisfy 2^CNT_W > max(NUM_WORDS, WORD_W).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a full configuration load.
- in_valid  input  1  in_data holds a valid configuration word.
- in_ready  output  1  loader accepts a word this cycle.
- in_data  input  WORD_W  configuration word.
- scan_en  output  1  scan chain shifts one bit this cycle.
- scan_out  output  1  serial bit to scan chain, valid when scan_en=1.
- cfg_latch  output  1  one-cycle strobe: fabric copies scan chain to active config.
- fabric_en  output  1  fabric in user mode.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully (sticky until next start/reset).
- word_cnt  output  CNT_W  words fully shifted in current load.
- err  output  1  checksum failure (sticky); tied 0 unless CFG_CHECKSUM_EN.

Behaviour:
- Clock and reset: one clock domain, `clock`. Reset is synchronous and active-high, on `reset`.
- Reset values: all outputs registered.
  - Reset forces state IDLE and shift/bit counters to 0.
  - All outputs reset to 0: in_ready, scan_en, scan_out, cfg_latch, fabric_en, busy, done, err, word_cnt.
- Reset mid-load: the load is aborted, no cfg_latch is issued, and fabric_en stays 0.
- States: IDLE, LOAD, SHIFT, CHECK (feature only), LATCH, DONE, ERR.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 -> LOAD next cycle, with busy=1, done=0, err=0, fabric_en=0, word_cnt=0.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: capture in_data into the shift register, bit counter=0, -> SHIFT.
  - in_valid=0 holds LOAD indefinitely, with no timeout.
- SHIFT:
  - in_ready=0, scan_en=1, scan_out=shreg[WORD_W-1]; shreg shifts left one bit per cycle.
  - Lasts exactly WORD_W cycles.
  - On the last bit, word_cnt increments.
  - If the new count equals NUM_WORDS -> LATCH (or CHECK when the feature is enabled); otherwise -> LOAD.
  - scan_en drops to 0 in the following cycle.
- LATCH:
  - cfg_latch=1 for exactly one cycle -> DONE.
- DONE:
  - busy=0, done=1, fabric_en=1, word_cnt holds NUM_WORDS.
  - start=1 -> LOAD, with fabric_en=0 and done=0 in that same transition (reconfiguration).
- Start handling: start while busy=1 is ignored. in_valid outside LOAD is ignored, and no word is consumed.
- Timing: with in_valid held high, each word costs 1 LOAD cycle + WORD_W SHIFT cycles. If start is sampled at edge 0, cfg_latch is high in cycle NUM_WORDS*(WORD_W+1)+1 and done/fabric_en go high one cycle later.
- Scan-chain ordering: the first word accepted ends up deepest in the chain. Word ordering in the configuration file is the fabric's scan order.

Optional Feature:
- Macro: CFG_CHECKSUM_EN.
- Enabled:
  - After word NUM_WORDS, state CHECK asserts in_ready and accepts one extra word, which is not shifted.
  - That word is compared against the running XOR of all NUM_WORDS data words; the accumulator is cleared on start.
  - Match -> LATCH.
  - Mismatch -> ERR: err=1, busy=0, done=0, fabric_en=0, and no cfg_latch.
  - In ERR, start clears err and -> LOAD.
- Disabled: CHECK and ERR are not built, err is tied 0, and the stream carries exactly NUM_WORDS words.

Test Plan:
- WORD_W=4, NUM_WORDS=3, in_valid always high, words 4'hA, 4'h3, 4'hC, start at cycle 0 -> scan_out sequence 1010 0011 1100 with scan_en high in cycles 2-5, 7-10, 12-15; cfg_latch in cycle 16; done=fabric_en=1 from cycle 17; word_cnt=3.
- Same setup, in_valid dropped for 5 cycles before word 2 -> in_ready held 1, no scan_en during stall, serial data identical, cfg_latch delayed by exactly 5 cycles.
- start pulsed while in SHIFT, and in_valid=1 asserted in IDLE -> no restart, no word consumed, word_cnt unaffected.
- reset asserted in the middle of word 2 -> next cycle all outputs 0, no cfg_latch ever; a subsequent start performs a full clean load.
- From DONE, issue start -> fabric_en falls the cycle after start, a full reload follows, and a second cfg_latch fires.
- CFG_CHECKSUM_EN: checksum word 4'h5 (A^3^C) -> cfg_latch, done=1. Checksum word 4'h4 -> err=1, fabric_en=0, no cfg_latch; the next start clears err.

Source files
------------

// File: rtl/cfg_scan_loader.sv
// Configuration loader: accepts words over valid/ready and shifts them MSB first into the fabric scan chain.
// Define CFG_CHECKSUM_EN to accept a trailing XOR checksum word before the latch strobe.
module cfg_scan_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 42,
    parameter int CNT_W     = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              scan_en,
    output logic              scan_out,
    output logic              cfg_latch,
    output logic              fabric_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] LATCH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
`ifdef CFG_CHECKSUM_EN
    localparam logic [2:0] CHECK = 3'd5;
    localparam logic [2:0] ERR   = 3'd6;
`endif

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS);

    logic [2:0]        state_reg, state_next;
    logic [WORD_W-1:0] shreg_reg, shreg_next, shifted;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [CNT_W-1:0]  word_cnt_reg, word_cnt_next, word_inc;
    logic              in_ready_reg, scan_en_reg, cfg_latch_reg;
    logic              fabric_en_reg, busy_reg, done_reg;
    logic              restart, ready_state, busy_state;
`ifdef CFG_CHECKSUM_EN
    logic [WORD_W-1:0] xor_reg, xor_next;
    logic              err_reg;
`endif

    // Left shift feeding zeros, so scan_out idles low once a word has drained.
    genvar gi;
    assign shifted[0] = 1'b0;
    generate
        for (gi = 1; gi < WORD_W; gi++) begin : g_shift
            assign shifted[gi] = shreg_reg[gi-1];
        end
    endgenerate

    assign word_inc = word_cnt_reg + CNT_W'(1);

    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        bit_cnt_next  = bit_cnt_reg;
        word_cnt_next = word_cnt_reg;
        restart       = 1'b0;
`ifdef CFG_CHECKSUM_EN
        xor_next      = xor_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    restart    = 1'b1;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    shreg_next   = in_data;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
`ifdef CFG_CHECKSUM_EN
                    xor_next     = xor_reg ^ in_data;
`endif
                end
            end
            SHIFT: begin
                shreg_next   = shifted;
                bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                if (bit_cnt_reg == LAST_BIT) begin
                    word_cnt_next = word_inc;
                    if (word_inc == LAST_WORD) begin
`ifdef CFG_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = LATCH;
`endif
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
`ifdef CFG_CHECKSUM_EN
            CHECK: begin
                if (in_valid) begin
                    state_next = (in_data == xor_reg) ? LATCH : ERR;
                end
            end
            ERR: begin
                if (start) begin
                    state_next = LOAD;
                    restart    = 1'b1;
                end
            end
`endif
            LATCH: state_next = DONE;
            DONE: begin
                if (start) begin
                    state_next = LOAD;
                    restart    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (restart) begin
            word_cnt_next = '0;
`ifdef CFG_CHECKSUM_EN
            xor_next      = '0;
`endif
        end
    end

    // Outputs are decoded from the next state so they are registered yet aligned with the state.
    always_comb begin
        ready_state = (state_next == LOAD);
        busy_state  = (state_next == LOAD) || (state_next == SHIFT) || (state_next == LATCH);
`ifdef CFG_CHECKSUM_EN
        ready_state = ready_state || (state_next == CHECK);
        busy_state  = busy_state || (state_next == CHECK);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            bit_cnt_reg   <= '0;
            word_cnt_reg  <= '0;
            in_ready_reg  <= 1'b0;
            scan_en_reg   <= 1'b0;
            cfg_latch_reg <= 1'b0;
            fabric_en_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            xor_reg       <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            bit_cnt_reg   <= bit_cnt_next;
            word_cnt_reg  <= word_cnt_next;
            in_ready_reg  <= ready_state;
            scan_en_reg   <= (state_next == SHIFT);
            cfg_latch_reg <= (state_next == LATCH);
            fabric_en_reg <= (state_next == DONE);
            busy_reg      <= busy_state;
            done_reg      <= (state_next == DONE);
`ifdef CFG_CHECKSUM_EN
            xor_reg       <= xor_next;
            err_reg       <= (state_next == ERR);
`endif
        end
    end

    assign in_ready  = in_ready_reg;
    assign scan_en   = scan_en_reg;
    assign scan_out  = shreg_reg[WORD_W-1];
    assign cfg_latch = cfg_latch_reg;
    assign fabric_en = fabric_en_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign word_cnt  = word_cnt_reg;
`ifdef CFG_CHECKSUM_EN
    assign err       = err_reg;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_scan_loader.sv
// Directed bench for cfg_scan_loader (WORD_W=4, NUM_WORDS=3): serial stream model plus cycle-exact expectations.
module tb_cfg_scan_loader;

    localparam int WW = 4;
    localparam int NW = 3;
    localparam int CW = 4;
`ifdef CFG_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_ready, scan_en, scan_out, cfg_latch, fabric_en, busy, done, err;
    logic [CW-1:0] word_cnt;

    cfg_scan_loader #(.WORD_W(WW), .NUM_WORDS(NW), .CNT_W(CW)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .scan_en  (scan_en),
        .scan_out (scan_out),
        .cfg_latch(cfg_latch),
        .fabric_en(fabric_en),
        .busy     (busy),
        .done     (done),
        .word_cnt (word_cnt),
        .err      (err)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            bit_idx = 0;
    int            latch_rel = -1;
    int            done_rel = -1;
    int            lat_cnt = 0;
    int            load_no = 0;
    logic [63:0]   sen_mask = '0;
    logic [63:0]   ser_bits = '0;
    logic [WW-1:0] exp_words [NW];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Per-cycle comparison against the load model: serial stream is the words MSB first, in order.
    task automatic monitor();
        int   rel;
        int   wi;
        logic exp_bit;
        if (reset) return;
        rel = cyc - start_cyc;
        chk("ready_and_shift_overlap", {63'd0, in_ready & scan_en}, 64'd0);
        chk("fabric_en_tracks_done", {63'd0, fabric_en}, {63'd0, done});
        if (busy === 1'b1)
            chk("word_cnt_progress", {60'd0, word_cnt}, 64'(bit_idx / WW));
        if (scan_en === 1'b1) begin
            if (rel >= 0 && rel < 64) sen_mask[rel] = 1'b1;
            ser_bits = {ser_bits[62:0], scan_out};
            chk("scan_bit_within_load", {63'd0, bit_idx < NW * WW}, 64'd1);
            if (bit_idx < NW * WW) begin
                wi      = bit_idx / WW;
                exp_bit = exp_words[wi][WW-1-(bit_idx % WW)];
                chk("scan_out_bit", {63'd0, scan_out}, {63'd0, exp_bit});
            end
            bit_idx++;
        end
        if (cfg_latch === 1'b1) begin
            chk("all_bits_before_latch", 64'(bit_idx), 64'(NW * WW));
            lat_cnt++;
            if (latch_rel < 0) latch_rel = rel;
        end
        if (done === 1'b1 && latch_rel >= 0 && done_rel < 0) done_rel = rel;
    endtask

    task automatic tick();
        @(negedge clock);
        monitor();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic load_begin(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input logic [WW-1:0] w2);
        exp_words[0] = w0;
        exp_words[1] = w1;
        exp_words[2] = w2;
        bit_idx   = 0;
        sen_mask  = '0;
        ser_bits  = '0;
        latch_rel = -1;
        done_rel  = -1;
        start_cyc = cyc;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = w0;
        tick();
        start     = 1'b0;
        load_no++;
    endtask

    task automatic send_word(input logic [WW-1:0] w, input int stall);
        int n;
        if (stall > 0) begin
            in_valid = 1'b0;
        end else begin
            in_valid = 1'b1;
            in_data  = w;
        end
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("in_ready_reached", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < stall; i++) begin
            chk("ready_held_in_stall", {63'd0, in_ready}, 64'd1);
            tick();
        end
        in_valid = 1'b1;
        in_data  = w;
        tick();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("done_or_err_reached", {63'd0, done | err}, 64'd1);
        tick();
        $display("load %0d: words %h %h %h latch at cycle %0d done at cycle %0d scan_en mask %0h",
                 load_no, exp_words[0], exp_words[1], exp_words[2], latch_rel, done_rel, sen_mask);
    endtask

    task automatic full_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input logic [WW-1:0] w2,
                             input int stall, input bit reconf);
        load_begin(w0, w1, w2);
        if (reconf) begin
            chk("reconf_fabric_en_low", {63'd0, fabric_en}, 64'd0);
            chk("reconf_done_low", {63'd0, done}, 64'd0);
            chk("reconf_busy_high", {63'd0, busy}, 64'd1);
            chk("reconf_word_cnt_clear", {60'd0, word_cnt}, 64'd0);
        end
        send_word(w0, 0);
        send_word(w1, stall);
        send_word(w2, 0);
`ifdef CFG_CHECKSUM_EN
        send_word(w0 ^ w1 ^ w2, 0);
`endif
        in_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with in_valid high: nothing may be accepted while idle.
        in_valid = 1'b1;
        in_data  = 4'hA;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_outputs_zero",
            {52'd0, in_ready, scan_en, scan_out, cfg_latch, fabric_en, busy, done, err, word_cnt}, 64'd0);
        tick();
        tick();
        tick();
        chk("idle_ignores_valid", {61'd0, in_ready, busy, scan_en}, 64'd0);
        chk("idle_word_cnt", {60'd0, word_cnt}, 64'd0);

        // Basic load A,3,C with in_valid always high.
        full_load(4'hA, 4'h3, 4'hC, 0, 1'b0);
        chk("basic_latch_cycle", 64'(latch_rel), 64'(16 + CK));
        chk("basic_done_cycle", 64'(done_rel), 64'(17 + CK));
        chk("basic_scan_en_mask", sen_mask, 64'hF7BC);
        chk("basic_serial_bits", ser_bits, 64'hA3C);
        chk("basic_word_cnt", {60'd0, word_cnt}, 64'd3);
        chk("basic_done_fabric", {62'd0, done, fabric_en}, 64'd3);
        chk("basic_latch_count", 64'(lat_cnt), 64'd1);

        // Reconfiguration from DONE, with a 5-cycle stall before word 2.
        chk("pre_reconf_fabric_en", {63'd0, fabric_en}, 64'd1);
        full_load(4'hA, 4'h3, 4'hC, 5, 1'b1);
        chk("stall_latch_cycle", 64'(latch_rel), 64'(21 + CK));
        chk("stall_scan_en_mask", sen_mask, 64'h1EF03C);
        chk("stall_serial_bits", ser_bits, 64'hA3C);
        chk("stall_latch_count", 64'(lat_cnt), 64'd2);

        // start pulsed mid-shift must be ignored.
        load_begin(4'h5, 4'h9, 4'h6);
        send_word(4'h5, 0);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignored_start_busy", {63'd0, busy}, 64'd1);
        chk("ignored_start_shift", {63'd0, scan_en}, 64'd1);
        chk("ignored_start_word_cnt", {60'd0, word_cnt}, 64'd0);
        send_word(4'h9, 0);
        send_word(4'h6, 0);
`ifdef CFG_CHECKSUM_EN
        send_word(4'hA, 0);
`endif
        in_valid = 1'b0;
        wait_done();
        chk("ignored_start_latch_cycle", 64'(latch_rel), 64'(16 + CK));
        chk("ignored_start_serial", ser_bits, 64'h596);
        chk("ignored_start_latch_count", 64'(lat_cnt), 64'd3);

        // Reset in the middle of word 2 aborts the load without a latch.
        load_begin(4'hA, 4'h3, 4'hC);
        send_word(4'hA, 0);
        send_word(4'h3, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_outputs_zero",
            {52'd0, in_ready, scan_en, scan_out, cfg_latch, fabric_en, busy, done, err, word_cnt}, 64'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_no_latch", 64'(lat_cnt), 64'd3);
        chk("abort_fabric_off", {63'd0, fabric_en}, 64'd0);
        full_load(4'hC, 4'hA, 4'h3, 0, 1'b0);
        chk("post_abort_latch_cycle", 64'(latch_rel), 64'(16 + CK));
        chk("post_abort_scan_en_mask", sen_mask, 64'hF7BC);
        chk("post_abort_serial", ser_bits, 64'hCA3);
        chk("post_abort_word_cnt", {60'd0, word_cnt}, 64'd3);
        chk("post_abort_latch_count", 64'(lat_cnt), 64'd4);

`ifdef CFG_CHECKSUM_EN
        // Wrong checksum 4'h4 for A,3,C: error, no latch; next start clears err.
        load_begin(4'hA, 4'h3, 4'hC);
        send_word(4'hA, 0);
        send_word(4'h3, 0);
        send_word(4'hC, 0);
        send_word(4'h4, 0);
        in_valid = 1'b0;
        wait_done();
        chk("cksum_bad_err", {63'd0, err}, 64'd1);
        chk("cksum_bad_outputs", {61'd0, fabric_en, done, busy}, 64'd0);
        chk("cksum_bad_no_latch", 64'(lat_cnt), 64'd4);
        load_begin(4'hA, 4'h3, 4'hC);
        chk("cksum_err_cleared", {63'd0, err}, 64'd0);
        send_word(4'hA, 0);
        send_word(4'h3, 0);
        send_word(4'hC, 0);
        send_word(4'h5, 0);
        in_valid = 1'b0;
        wait_done();
        chk("cksum_good_done", {62'd0, done, fabric_en}, 64'd3);
        chk("cksum_good_latch_count", 64'(lat_cnt), 64'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
